// File: rtl/muldiv_unit_if.sv
// Command/result bundle between the execute stage (master) and muldiv_unit (slave).
interface muldiv_unit_if;
   logic        Start;
   logic [2:0]  MdOp;
   logic [31:0] Rs;
   logic [31:0] Rt;
   logic        Busy;
   logic        Done;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start, MdOp, Rs, Rt,
      input  Busy, Done, HI, LO
   );

   modport slave (
      input  Start, MdOp, Rs, Rt,
      output Busy, Done, HI, LO
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO pair.
// The restoring divider is present only when MULDIV_DIV_EN is defined.
module muldiv_unit (
   input logic          CLK,
   input logic          RST,
   muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;

   state_e      state_q;
   logic [4:0]  cnt_q;
   logic [31:0] opa_q;
   logic [63:0] acc_q;
   logic        neg_lo_q;
   logic        is_div_q;
   logic        done_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic        sgn_op;
   logic        rs_neg;
   logic        rt_neg;
   logic [31:0] rs_mag;
   logic [31:0] rt_mag;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [63:0] prod;
`ifdef MULDIV_DIV_EN
   logic        neg_hi_q;
   logic [32:0] rem_sh;
   logic [63:0] div_next;
   logic [31:0] quo;
   logic [31:0] rem;
`endif

   always_comb begin
      sgn_op   = (bus.MdOp == OpMult) || (bus.MdOp == OpDiv);
      rs_neg   = sgn_op & bus.Rs[31];
      rt_neg   = sgn_op & bus.Rt[31];
      rs_mag   = rs_neg ? (~bus.Rs + 32'd1) : bus.Rs;
      rt_mag   = rt_neg ? (~bus.Rt + 32'd1) : bus.Rt;
      // Multiply: upper half accumulates, multiplier shifts out of the lower half.
      mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opa_q};
      mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:32], acc_q[31:1]};
      prod     = neg_lo_q ? (~acc_q + 64'd1) : acc_q;
`ifdef MULDIV_DIV_EN
      // Divide: remainder in the upper half, dividend shifts out as quotient shifts in.
      rem_sh   = {acc_q[63:32], acc_q[31]};
      div_next = (rem_sh >= {1'b0, opa_q}) ? {rem_sh[31:0] - opa_q, acc_q[30:0], 1'b1}
                                           : {rem_sh[31:0], acc_q[30:0], 1'b0};
      quo      = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      rem      = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
`endif
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= StIdle;
         cnt_q    <= 5'd0;
         opa_q    <= 32'd0;
         acc_q    <= 64'd0;
         neg_lo_q <= 1'b0;
         is_div_q <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
`ifdef MULDIV_DIV_EN
         neg_hi_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.Start) begin
                  case (bus.MdOp)
                     OpMthi: hi_q <= bus.Rs;
                     OpMtlo: lo_q <= bus.Rs;
                     OpMult, OpMultu: begin
                        opa_q    <= rs_mag;
                        acc_q    <= {32'd0, rt_mag};
                        neg_lo_q <= rs_neg ^ rt_neg;
                        is_div_q <= 1'b0;
                        cnt_q    <= 5'd0;
                        state_q  <= StRun;
                     end
                     OpDiv, OpDivu: begin
                        is_div_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                        opa_q    <= rt_mag;
                        acc_q    <= {32'd0, rs_mag};
                        // Zero divisor keeps the all-ones quotient unsigned.
                        neg_lo_q <= (rs_neg ^ rt_neg) && (bus.Rt != 32'd0);
                        neg_hi_q <= rs_neg;
                        cnt_q    <= 5'd0;
                        state_q  <= StRun;
`else
                        state_q  <= StFix;
`endif
                     end
                     default: ;
                  endcase
               end
            end
            StRun: begin
               cnt_q <= cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
               acc_q <= is_div_q ? div_next : mul_next;
`else
               acc_q <= mul_next;
`endif
               if (cnt_q == 5'd31) state_q <= StFix;
            end
            StFix: begin
               if (!is_div_q) begin
                  hi_q <= prod[63:32];
                  lo_q <= prod[31:0];
               end
`ifdef MULDIV_DIV_EN
               else begin
                  hi_q <= rem;
                  lo_q <= quo;
               end
`endif
               done_q  <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.Busy = (state_q != StIdle);
   assign bus.Done = done_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random commands against
// an arithmetic reference model of HI/LO.
module tb_muldiv_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;

   muldiv_unit_if bus();

   muldiv_unit dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;

`ifdef MULDIV_DIV_EN
   localparam int DivBusy = 33;
`else
   localparam int DivBusy = 1;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         3'd0: begin
            p = sa * sb;
            hi_m = p[63:32];
            lo_m = p[31:0];
         end
         3'd1: begin
            p = {32'd0, a} * {32'd0, b};
            hi_m = p[63:32];
            lo_m = p[31:0];
         end
`ifdef MULDIV_DIV_EN
         3'd2: begin
            if (b == 32'd0) begin
               lo_m = 32'hFFFF_FFFF;
               hi_m = a;
            end else begin
               lo_m = 32'(sa / sb);
               hi_m = 32'(sa % sb);
            end
         end
         3'd3: begin
            if (b == 32'd0) begin
               lo_m = 32'hFFFF_FFFF;
               hi_m = a;
            end else begin
               lo_m = a / b;
               hi_m = a % b;
            end
         end
`endif
         3'd4: hi_m = a;
         3'd5: lo_m = a;
         default: ;
      endcase
   endtask

   // Starts in any cycle with the unit idle or pulsing Done; returns in the Done cycle.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inj);
      int busy;
      int k;
      bit stable;
      int exp_busy;
      busy     = 0;
      k        = 0;
      stable   = 1'b1;
      exp_busy = (op < 3'd2) ? 33 : DivBusy;
      bus.Start = 1'b1;
      bus.MdOp  = op;
      bus.Rs    = a;
      bus.Rt    = b;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      bus.Rs    = $urandom;
      bus.Rt    = $urandom;
      chk($sformatf("op%0d done_low_after_accept", op), {63'd0, bus.Done}, 64'd0);
      while (bus.Done !== 1'b1 && k < 100) begin
         if (bus.Busy === 1'b1) busy++;
         if (bus.HI !== hi_m || bus.LO !== lo_m) stable = 1'b0;
         if (inj && k == 4) begin
            bus.Start = 1'b1;
            bus.MdOp  = 3'd5;
            bus.Rs    = 32'hDEAD_BEEF;
         end else begin
            bus.Start = 1'b0;
         end
         @(posedge clk);
         #1;
         k++;
      end
      bus.Start = 1'b0;
      chk($sformatf("op%0d done_seen", op), {63'd0, bus.Done}, 64'd1);
      chk($sformatf("op%0d busy_cycles", op), 64'(busy), 64'(exp_busy));
      chk($sformatf("op%0d hilo_hold", op), {63'd0, stable}, 64'd1);
      chk($sformatf("op%0d busy_in_done", op), {63'd0, bus.Busy}, 64'd0);
      model(op, a, b);
      chk($sformatf("op%0d hi %h %h", op, a, b), {32'd0, bus.HI}, {32'd0, hi_m});
      chk($sformatf("op%0d lo %h %h", op, a, b), {32'd0, bus.LO}, {32'd0, lo_m});
   endtask

   task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
      bus.Start = 1'b1;
      bus.MdOp  = op;
      bus.Rs    = a;
      bus.Rt    = $urandom;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      model(op, a, 32'd0);
      chk($sformatf("mt%0d hi", op), {32'd0, bus.HI}, {32'd0, hi_m});
      chk($sformatf("mt%0d lo", op), {32'd0, bus.LO}, {32'd0, lo_m});
      chk($sformatf("mt%0d busy", op), {63'd0, bus.Busy}, 64'd0);
      chk($sformatf("mt%0d done", op), {63'd0, bus.Done}, 64'd0);
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0] op;
      bus.Start = 1'b0;
      bus.MdOp  = 3'd0;
      bus.Rs    = 32'd0;
      bus.Rt    = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {63'd0, bus.Busy}, 64'd0);
      chk("reset done", {63'd0, bus.Done}, 64'd0);
      chk("reset hi", {32'd0, bus.HI}, 64'd0);
      chk("reset lo", {32'd0, bus.LO}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      run_mt(3'd4, 32'h0000_1234);
      chk("mthi literal", {32'd0, bus.HI}, 64'h1234);
      chk("mthi lo kept", {32'd0, bus.LO}, 64'd0);

      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("multu max hi", {32'd0, bus.HI}, 64'hFFFF_FFFE);
      chk("multu max lo", {32'd0, bus.LO}, 64'h0000_0001);
      run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
      chk("mult -3*7 hi", {32'd0, bus.HI}, 64'hFFFF_FFFF);
      chk("mult -3*7 lo", {32'd0, bus.LO}, 64'hFFFF_FFEB);
      run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
      chk("multu hi", {32'd0, bus.HI}, 64'h0000_0006);
      chk("multu lo", {32'd0, bus.LO}, 64'hFFFF_FFEB);

      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef MULDIV_DIV_EN
      chk("div -7/2 lo", {32'd0, bus.LO}, 64'hFFFF_FFFD);
      chk("div -7/2 hi", {32'd0, bus.HI}, 64'hFFFF_FFFF);
`endif
      run_op(3'd3, 32'd7, 32'd2, 1'b0);
`ifdef MULDIV_DIV_EN
      chk("divu 7/2 lo", {32'd0, bus.LO}, 64'd3);
      chk("divu 7/2 hi", {32'd0, bus.HI}, 64'd1);
`endif
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
`ifdef MULDIV_DIV_EN
      chk("div ovf lo", {32'd0, bus.LO}, 64'h8000_0000);
      chk("div ovf hi", {32'd0, bus.HI}, 64'd0);
`endif
      run_op(3'd3, 32'd5, 32'd0, 1'b0);
`ifdef MULDIV_DIV_EN
      chk("divu by0 lo", {32'd0, bus.LO}, 64'hFFFF_FFFF);
      chk("divu by0 hi", {32'd0, bus.HI}, 64'd5);
`endif
      run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);

      // MTLO while busy must be dropped.
      run_op(3'd1, 32'h0001_0003, 32'h0000_0100, 1'b1);
      chk("mtlo busy ignored", {32'd0, bus.LO}, 64'h0100_0300);

      run_mt(3'd6, 32'hCAFE_F00D);
      run_mt(3'd5, 32'h0BAD_0BAD);

      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 7));
         if (op >= 3'd4) run_mt(op, rnd_opnd());
         else run_op(op, rnd_opnd(), rnd_opnd(), 1'b0);
      end

      @(posedge clk);
      #1;
      chk("done one cycle", {63'd0, bus.Done}, 64'd0);

      // Asynchronous reset with the counter at 10.
      bus.Start = 1'b1;
      bus.MdOp  = 3'd1;
      bus.Rs    = 32'h1234_5678;
      bus.Rt    = 32'h9ABC_DEF0;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("busy before reset", {63'd0, bus.Busy}, 64'd1);
      rst = 1'b0;
      #1;
      chk("async rst busy", {63'd0, bus.Busy}, 64'd0);
      chk("async rst done", {63'd0, bus.Done}, 64'd0);
      chk("async rst hi", {32'd0, bus.HI}, 64'd0);
      chk("async rst lo", {32'd0, bus.LO}, 64'd0);
      hi_m = 32'd0;
      lo_m = 32'd0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      run_op(3'd1, 32'd3, 32'd5, 1'b0);
      chk("post rst lo", {32'd0, bus.LO}, 64'd15);
      chk("post rst hi", {32'd0, bus.HI}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
